// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the walking-ones memory test sequencer.
// Used by mem_test_ctrl; the optional error counter is selected with MEMTEST_ERRCNT_EN.
package mem_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int unsigned PAT_MAX_WIDTH = 64;
   typedef logic [PAT_MAX_WIDTH-1:0] pat_t;

   // One-hot seed: LSB set.
   localparam pat_t PAT_INIT = 64'd1;

   // Rotate left by one within the low w bits; the MSB wraps into the LSB.
   function automatic pat_t rotl1(input pat_t p, input int unsigned w);
      pat_t mask;
      if (w >= PAT_MAX_WIDTH) begin
         mask = {PAT_MAX_WIDTH{1'b1}};
      end else begin
         mask = (64'd1 << w) - 64'd1;
      end
      return ((p << 1) | (p >> (w - 32'd1))) & mask;
   endfunction

endpackage

// File: rtl/mem_test_ctrl_cmp.sv
// Generic equality comparator, used for range termination and read-data checking.
module mem_test_ctrl_cmp #(
   parameter int p_WIDTH = 8
) (
   input  logic [p_WIDTH-1:0] i_A,
   input  logic [p_WIDTH-1:0] i_B,
   output logic               o_EQ
);

   assign o_EQ = (i_A == i_B);

endmodule

// File: rtl/mem_test_ctrl.sv
// Walking-ones memory test sequencer: write a rotating one-hot pattern over a range, read back, compare.
// Define MEMTEST_ERRCNT_EN to add the o_ERR_CNT port and its saturating mismatch counter.
module mem_test_ctrl
   import mem_test_pkg::*;
#(
   parameter int p_ADDR_WIDTH = 8,
   parameter int p_DATA_WIDTH = 8,
   parameter int p_ERR_WIDTH  = 8
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic                    i_START,
   input  logic                    i_ABORT,
   input  logic [p_ADDR_WIDTH-1:0] i_ADDR_START,
   input  logic [p_ADDR_WIDTH-1:0] i_ADDR_END,
   output logic                    o_BUSY,
   output logic                    o_DONE,
   output logic                    o_PASS,
   output logic                    o_CFG_ERR,
   output logic [p_ADDR_WIDTH-1:0] o_FAIL_ADDR,
`ifdef MEMTEST_ERRCNT_EN
   output logic [p_ERR_WIDTH-1:0]  o_ERR_CNT,
`endif
   output logic                    o_MEM_EN,
   output logic                    o_MEM_WE,
   output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
   output logic [p_DATA_WIDTH-1:0] o_MEM_WDATA,
   input  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA
);

   localparam logic [p_DATA_WIDTH-1:0] PAT_INIT_C = p_DATA_WIDTH'(PAT_INIT);

   state_t                  state_r;
   state_t                  state_nx_s;
   logic [p_ADDR_WIDTH-1:0] start_r;
   logic [p_ADDR_WIDTH-1:0] end_r;
   logic [p_ADDR_WIDTH-1:0] cnt_r;
   logic [p_DATA_WIDTH-1:0] pat_r;
   logic [p_DATA_WIDTH-1:0] pat_rot_s;
   logic [p_DATA_WIDTH-1:0] exp_r;
   logic [p_ADDR_WIDTH-1:0] cmp_addr_r;
   logic                    cmp_vld_r;
   logic                    err_seen_r;
   logic                    pass_r;
   logic                    cfg_err_r;
   logic [p_ADDR_WIDTH-1:0] fail_addr_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    mem_en_r;
   logic                    mem_we_r;
   logic                    cnt_at_end_s;
   logic                    rdata_eq_s;
   logic                    range_bad_s;
   logic                    start_go_s;
   logic                    stepping_s;
   logic                    mism_s;
`ifdef MEMTEST_ERRCNT_EN
   logic [p_ERR_WIDTH-1:0]  err_cnt_r;
`endif

   mem_test_ctrl_cmp #(.p_WIDTH(p_ADDR_WIDTH)) u_cmp_end (
      .i_A  (cnt_r),
      .i_B  (end_r),
      .o_EQ (cnt_at_end_s)
   );

   mem_test_ctrl_cmp #(.p_WIDTH(p_DATA_WIDTH)) u_cmp_data (
      .i_A  (i_MEM_RDATA),
      .i_B  (exp_r),
      .o_EQ (rdata_eq_s)
   );

   assign pat_rot_s = p_DATA_WIDTH'(rotl1(pat_t'(pat_r), p_DATA_WIDTH));

   // Start qualification, range check, address stepping and compare-stage mismatch.
   always_comb begin
      range_bad_s = (i_ADDR_START > i_ADDR_END);
      start_go_s  = (state_r == ST_IDLE) && i_START && !i_ABORT;
      stepping_s  = ((state_r == ST_WRITE) || (state_r == ST_READ)) && !i_ABORT;
      mism_s      = cmp_vld_r && !rdata_eq_s && !i_ABORT;
   end

   // Next-state logic; abort wins over everything, including start.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (i_START) begin
               if (range_bad_s) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_WRITE;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (i_ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_at_end_s) begin
               state_nx_s = ST_READ;
            end else begin
               state_nx_s = ST_WRITE;
            end
         end
         ST_READ: begin
            if (i_ABORT) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_at_end_s) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (i_ABORT) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register plus control outputs registered from the next state.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_r  <= ST_IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         mem_en_r <= 1'b0;
         mem_we_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         busy_r   <= (state_nx_s == ST_WRITE) || (state_nx_s == ST_READ) ||
                     (state_nx_s == ST_DRAIN);
         done_r   <= (state_nx_s == ST_DONE);
         mem_en_r <= (state_nx_s == ST_WRITE) || (state_nx_s == ST_READ);
         mem_we_r <= (state_nx_s == ST_WRITE);
      end
   end

   // Range latch, address counter and pattern; counter reloads on END so it never wraps.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         start_r <= {p_ADDR_WIDTH{1'b0}};
         end_r   <= {p_ADDR_WIDTH{1'b0}};
         cnt_r   <= {p_ADDR_WIDTH{1'b0}};
         pat_r   <= {p_DATA_WIDTH{1'b0}};
      end else if (start_go_s) begin
         start_r <= i_ADDR_START;
         end_r   <= i_ADDR_END;
         cnt_r   <= i_ADDR_START;
         pat_r   <= PAT_INIT_C;
      end else if (stepping_s) begin
         if (cnt_at_end_s) begin
            cnt_r <= start_r;
            pat_r <= PAT_INIT_C;
         end else begin
            cnt_r <= cnt_r + p_ADDR_WIDTH'(1'b1);
            pat_r <= pat_rot_s;
         end
      end
   end

   // One-deep compare pipeline: expected data and address of the read issued this cycle.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         cmp_vld_r  <= 1'b0;
         exp_r      <= {p_DATA_WIDTH{1'b0}};
         cmp_addr_r <= {p_ADDR_WIDTH{1'b0}};
      end else begin
         cmp_vld_r <= (state_r == ST_READ) && !i_ABORT;
         if (state_r == ST_READ) begin
            exp_r      <= pat_r;
            cmp_addr_r <= cnt_r;
         end
      end
   end

   // Result flags: first-fail capture, pass at completion, cleared on start, pass dropped on abort.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         err_seen_r  <= 1'b0;
         pass_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
         fail_addr_r <= {p_ADDR_WIDTH{1'b0}};
      end else if (start_go_s) begin
         err_seen_r  <= 1'b0;
         pass_r      <= 1'b0;
         cfg_err_r   <= range_bad_s;
         fail_addr_r <= {p_ADDR_WIDTH{1'b0}};
      end else begin
         if (mism_s) begin
            err_seen_r <= 1'b1;
            if (!err_seen_r) begin
               fail_addr_r <= cmp_addr_r;
            end
         end
         if (i_ABORT) begin
            pass_r <= 1'b0;
         end else if (state_nx_s == ST_DONE) begin
            pass_r <= !(err_seen_r || mism_s) && !cfg_err_r;
         end
      end
   end

`ifdef MEMTEST_ERRCNT_EN
   // Saturating mismatch counter.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         err_cnt_r <= {p_ERR_WIDTH{1'b0}};
      end else if (start_go_s) begin
         err_cnt_r <= {p_ERR_WIDTH{1'b0}};
      end else if (mism_s && (err_cnt_r != {p_ERR_WIDTH{1'b1}})) begin
         err_cnt_r <= err_cnt_r + p_ERR_WIDTH'(1'b1);
      end
   end

   assign o_ERR_CNT = err_cnt_r;
`endif

   assign o_BUSY      = busy_r;
   assign o_DONE      = done_r;
   assign o_PASS      = pass_r;
   assign o_CFG_ERR   = cfg_err_r;
   assign o_FAIL_ADDR = fail_addr_r;
   assign o_MEM_EN    = mem_en_r;
   assign o_MEM_WE    = mem_we_r;
   assign o_MEM_ADDR  = cnt_r;
   assign o_MEM_WDATA = pat_r;

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Directed self-checking bench for mem_test_ctrl with a behavioural synchronous memory.
// Error-count checks are compiled in when MEMTEST_ERRCNT_EN is defined.
module tb_mem_test_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] addr_start = 8'h00;
   logic [7:0] addr_end = 8'h00;
   logic       busy, done, pass, cfg_err;
   logic [7:0] fail_addr;
`ifdef MEMTEST_ERRCNT_EN
   logic [7:0] err_cnt;
`endif
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] rd_mask = 8'hFF;
   logic [7:0] mem [0:255];

   int checks = 0;
   int failures = 0;
   int en_cnt = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int done_cyc;
   int busy_cnt;
   int done_seen;

   always #5 clk = ~clk;

   mem_test_ctrl dut (
      .i_CLK        (clk),
      .i_RST        (rst),
      .i_START      (start),
      .i_ABORT      (abort),
      .i_ADDR_START (addr_start),
      .i_ADDR_END   (addr_end),
      .o_BUSY       (busy),
      .o_DONE       (done),
      .o_PASS       (pass),
      .o_CFG_ERR    (cfg_err),
      .o_FAIL_ADDR  (fail_addr),
`ifdef MEMTEST_ERRCNT_EN
      .o_ERR_CNT    (err_cnt),
`endif
      .o_MEM_EN     (mem_en),
      .o_MEM_WE     (mem_we),
      .o_MEM_ADDR   (mem_addr),
      .o_MEM_WDATA  (mem_wdata),
      .i_MEM_RDATA  (mem_rdata)
   );

   // Synchronous memory; rd_mask models stuck-at-0 bits on the read path.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr] & rd_mask;
   end

   // Access counters sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_en) en_cnt <= en_cnt + 1;
      if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
      if (mem_en && !mem_we) rd_cnt <= rd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start with a range, then return at the negedge of the o_DONE cycle (or after the bound).
   task automatic run_test(input logic [7:0] s, input logic [7:0] e);
      int cyc;
      @(negedge clk);
      en_cnt = 0; wr_cnt = 0; rd_cnt = 0;
      addr_start = s; addr_end = e; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; done_cyc = -1; busy_cnt = 0;
      while (done_cyc < 0 && cyc < 600) begin
         if (busy) busy_cnt++;
         if (done) done_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_fail_addr", fail_addr, 8'h00);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_addr", mem_addr, 8'h00);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Ideal memory, 0x10..0x13
      run_test(8'h10, 8'h13);
      check("t1_done_cyc", done_cyc, 10);
      check("t1_busy_cycles", busy_cnt, 9);
      check("t1_pass", pass, 1'b1);
      check("t1_writes", wr_cnt, 4);
      check("t1_reads", rd_cnt, 4);
      check("t1_mem10", mem[8'h10], 8'h01);
      check("t1_mem11", mem[8'h11], 8'h02);
      check("t1_mem12", mem[8'h12], 8'h04);
      check("t1_mem13", mem[8'h13], 8'h08);
`ifdef MEMTEST_ERRCNT_EN
      check("t1_err_cnt", err_cnt, 8'd0);
`endif
      @(negedge clk);
      check("t1_done_one_cycle", done, 1'b0);
      check("t1_pass_held", pass, 1'b1);

      // Bit 2 stuck at 0, 0x00..0x09: only index 2 carries bit 2; index 8 wraps to 0x01
      rd_mask = 8'hFB;
      run_test(8'h00, 8'h09);
      check("t2_done_cyc", done_cyc, 22);
      check("t2_pass", pass, 1'b0);
      check("t2_fail_addr", fail_addr, 8'h02);
      check("t2_mem08", mem[8'h08], 8'h01);
      check("t2_mem09", mem[8'h09], 8'h02);
`ifdef MEMTEST_ERRCNT_EN
      check("t2_err_cnt", err_cnt, 8'd1);
`endif
      rd_mask = 8'hFF;

      // Single address at the top of the space
      run_test(8'hFF, 8'hFF);
      check("t3_done_cyc", done_cyc, 4);
      check("t3_pass", pass, 1'b1);
      check("t3_en_pulses", en_cnt, 2);
      check("t3_memFF", mem[8'hFF], 8'h01);
      check("t3_addr_no_wrap", mem_addr, 8'hFF);

      // Inverted range
      run_test(8'h20, 8'h1F);
      check("t4_done_cyc", done_cyc, 1);
      check("t4_cfg_err", cfg_err, 1'b1);
      check("t4_pass", pass, 1'b0);
      check("t4_en_pulses", en_cnt, 0);
      check("t4_busy_cycles", busy_cnt, 0);
      check("t4_fail_addr", fail_addr, 8'h00);

      // Abort in READ (reads occupy cycles 5..8 for N=4)
      @(negedge clk);
      addr_start = 8'h30; addr_end = 8'h33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_in_read", mem_en && !mem_we, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_en_after_abort", mem_en, 1'b0);
      check("t5_busy_after_abort", busy, 1'b0);
      check("t5_cfg_err_clear", cfg_err, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      check("t5_no_done", done_seen, 0);
      check("t5_pass", pass, 1'b0);
      check("t5_fail_addr", fail_addr, 8'h00);
      run_test(8'h30, 8'h33);
      check("t5_rerun_done_cyc", done_cyc, 10);
      check("t5_rerun_pass", pass, 1'b1);

      // Reset mid-WRITE
      @(negedge clk);
      addr_start = 8'h40; addr_end = 8'h47; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_in_write", mem_en && mem_we, 1'b1);
      rst = 1'b1;
      #1;
      check("t6_rst_en", mem_en, 1'b0);
      check("t6_rst_we", mem_we, 1'b0);
      check("t6_rst_addr", mem_addr, 8'h00);
      check("t6_rst_wdata", mem_wdata, 8'h00);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_pass", pass, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_test(8'h40, 8'h47);
      check("t6_done_cyc", done_cyc, 18);
      check("t6_pass", pass, 1'b1);
      check("t6_mem47", mem[8'h47], 8'h80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
